// File: rtl/adder_pkg.sv
// adder_pkg: shared mode flags and configuration limits for the pipelined adder
package adder_pkg;
  localparam int MIN_WIDTH = 8;
  localparam int MAX_WIDTH = 64;
  localparam int MIN_STAGES = 1;
  localparam int MAX_STAGES = 4;
  typedef struct packed {
    logic op_sub;
    logic signed_mode;
    logic sat_en;
  } mode_t;
  function automatic bit cfg_ok(input int w, input int s);
    return w >= MIN_WIDTH && w <= MAX_WIDTH && s >= MIN_STAGES && s <= MAX_STAGES && w % s == 0;
  endfunction
endpackage

// File: rtl/adder_slice.sv
// adder_slice: combinational W-bit ripple segment exposing the carry into and out of its MSB
module adder_slice #(
  parameter int W = 16
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         cin,
  output logic [W-1:0] s,
  output logic         cout,
  output logic         cmsb
);
  assign {cmsb, s[W-2:0]} = {1'b0, a[W-2:0]} + {1'b0, b[W-2:0]} + {{(W-1){1'b0}}, cin};
  assign {cout, s[W-1]} = {1'b0, a[W-1]} + {1'b0, b[W-1]} + {1'b0, cmsb};
endmodule

// File: rtl/pipelined_adder.sv
// pipelined_adder: STAGES-deep carry-segmented add/subtract with overflow and saturation
module pipelined_adder
  import adder_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             op_sub,
  input  logic             signed_mode,
  input  logic             sat_en,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             overflow
);
  localparam int SW = WIDTH / STAGES;
  localparam int L = STAGES - 1;
  localparam logic [WIDTH-1:0] SLICE_MASK = WIDTH'({SW{1'b1}});

  if (!cfg_ok(WIDTH, STAGES)) begin : g_bad_cfg
    $error("pipelined_adder: illegal WIDTH/STAGES combination");
  end

  logic             r_valid [STAGES];
  logic [WIDTH-1:0] r_a     [STAGES];
  logic [WIDTH-1:0] r_b     [STAGES];
  logic [WIDTH-1:0] r_s     [STAGES];
  logic             r_c     [STAGES];
  mode_t            r_m     [STAGES];
  logic             r_ovf;

  logic             w_v  [STAGES];
  logic [WIDTH-1:0] w_a  [STAGES];
  logic [WIDTH-1:0] w_b  [STAGES];
  logic [WIDTH-1:0] w_si [STAGES];
  logic [WIDTH-1:0] w_sn [STAGES];
  logic [SW-1:0]    w_ss [STAGES];
  logic             w_ci [STAGES];
  logic             w_co [STAGES];
  logic             w_cm [STAGES];
  mode_t            w_m  [STAGES];
  logic             w_en, w_ovf;
  logic [WIDTH-1:0] w_sat, w_fin;

  // Subtract folds into the same chain: b is inverted once at entry, carry-in becomes !cin
  for (genvar k = 0; k < STAGES; k++) begin : g_st
    if (k == 0) begin : g_in
      assign w_v[k]  = in_valid;
      assign w_a[k]  = a;
      assign w_b[k]  = op_sub ? ~b : b;
      assign w_ci[k] = cin ^ op_sub;
      assign w_m[k]  = '{op_sub, signed_mode, sat_en};
      assign w_si[k] = '0;
    end else begin : g_mid
      assign w_v[k]  = r_valid[k-1];
      assign w_a[k]  = r_a[k-1];
      assign w_b[k]  = r_b[k-1];
      assign w_ci[k] = r_c[k-1];
      assign w_m[k]  = r_m[k-1];
      assign w_si[k] = r_s[k-1];
    end
    adder_slice #(.W(SW)) u_slice (
      .a    (w_a[k][k*SW +: SW]),
      .b    (w_b[k][k*SW +: SW]),
      .cin  (w_ci[k]),
      .s    (w_ss[k]),
      .cout (w_co[k]),
      .cmsb (w_cm[k])
    );
    assign w_sn[k] = (w_si[k] & ~(SLICE_MASK << (k*SW))) | (WIDTH'(w_ss[k]) << (k*SW));
  end

  // On signed overflow the true sign is the opposite of the wrapped result's MSB
  assign w_ovf = w_m[L].signed_mode ? w_cm[L] ^ w_co[L] : w_co[L] ^ w_m[L].op_sub;
  assign w_sat = w_m[L].signed_mode ? {~w_sn[L][WIDTH-1], {(WIDTH-1){w_sn[L][WIDTH-1]}}}
                                    : {WIDTH{~w_m[L].op_sub}};
  assign w_fin = (w_m[L].sat_en && w_ovf) ? w_sat : w_sn[L];

  assign w_en      = !(r_valid[L] && !out_ready);
  assign in_ready  = w_en;
  assign out_valid = r_valid[L];
  assign sum       = r_s[L];
  assign cout      = r_c[L];
  assign overflow  = r_ovf;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < STAGES; k++) begin
        r_valid[k] <= 1'b0;
        r_a[k]     <= '0;
        r_b[k]     <= '0;
        r_s[k]     <= '0;
        r_c[k]     <= 1'b0;
        r_m[k]     <= '0;
      end
      r_ovf <= 1'b0;
    end else if (w_en) begin
      for (int k = 0; k < STAGES; k++) begin
        r_valid[k] <= w_v[k];
        r_a[k]     <= w_a[k];
        r_b[k]     <= w_b[k];
        r_s[k]     <= (k == L) ? w_fin : w_sn[k];
        r_c[k]     <= w_co[k];
        r_m[k]     <= w_m[k];
      end
      r_ovf <= w_ovf;
    end
  end
endmodule

// File: tb/tb_pipelined_adder.sv
// tb_pipelined_adder: scoreboard bench against an arithmetic reference model, WIDTH=16 STAGES=2
module tb_pipelined_adder;
  typedef struct packed {
    logic [15:0] s;
    logic        c;
    logic        o;
  } exp_t;

  logic        clk = 1'b0, rst_n = 1'b0, in_valid = 1'b0, out_ready = 1'b1;
  logic        cin = 1'b0, op_sub = 1'b0, signed_mode = 1'b0, sat_en = 1'b0;
  logic [15:0] a = '0, b = '0;
  logic        in_ready, out_valid, cout, overflow;
  logic [15:0] sum;

  exp_t sb[$];
  exp_t mon_e;
  int   n_checks = 0, n_fail = 0, stall_seen = 0;
  logic prev_stall = 1'b0, pc, po;
  logic [15:0] ps;

  always #5 clk = ~clk;

  pipelined_adder #(.WIDTH(16), .STAGES(2)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .cin(cin), .op_sub(op_sub), .signed_mode(signed_mode), .sat_en(sat_en),
    .out_valid(out_valid), .out_ready(out_ready), .sum(sum), .cout(cout), .overflow(overflow)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic exp_t model(input logic [15:0] x, input logic [15:0] y,
                                 input logic c, input logic op, input logic sm, input logic se);
    longint ux = longint'(x), uy = longint'(y), sx = longint'($signed(x)), sy = longint'($signed(y));
    longint lc = longint'(c), u, s;
    exp_t e;
    u = op ? ux - uy - lc : ux + uy + lc;
    s = op ? sx - sy - lc : sx + sy + lc;
    e.s = u[15:0];
    e.c = op ? (u >= 0) : (u > 65535);
    e.o = sm ? (s > 32767 || s < -32768) : (op ? (u < 0) : (u > 65535));
    if (se && e.o) e.s = sm ? (s > 0 ? 16'h7fff : 16'h8000) : (op ? 16'h0000 : 16'hffff);
    return e;
  endfunction

  task automatic send(input logic [15:0] x, input logic [15:0] y, input logic c,
                      input logic op, input logic sm, input logic se, input exp_t e);
    bit done = 0;
    in_valid = 1'b1; a = x; b = y; cin = c; op_sub = op; signed_mode = sm; sat_en = se;
    for (int i = 0; i < 200 && !done; i++) begin
      @(negedge clk);
      if (in_ready) begin
        sb.push_back(e);
        @(posedge clk);
        #1;
        done = 1;
      end
    end
    in_valid = 1'b0;
    if (!done) begin
      n_checks++; n_fail++;
      $display("FAIL accept_timeout: got no accept expected accept within 200 cycles");
    end
  endtask

  task automatic send_rand();
    logic [15:0] x, y;
    logic c, op, sm, se;
    x = 16'($urandom); y = 16'($urandom);
    c = 1'($urandom); op = 1'($urandom); sm = 1'($urandom); se = 1'($urandom);
    send(x, y, c, op, sm, se, model(x, y, c, op, sm, se));
  endtask

  task automatic drain();
    for (int i = 0; i < 200 && sb.size() != 0; i++) @(negedge clk);
    check("drain_empty", sb.size(), 0);
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (!rst_n) prev_stall = 1'b0;
    else begin
      check("in_ready_rule", in_ready, !(out_valid && !out_ready));
      if (prev_stall) begin
        check("hold_valid", out_valid, 1);
        check("hold_sum", sum, ps);
        check("hold_cout", cout, pc);
        check("hold_ovf", overflow, po);
      end
      if (!in_ready) stall_seen++;
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          n_checks++; n_fail++;
          $display("FAIL unexpected_output: got sum %0h expected no output", sum);
        end else begin
          mon_e = sb.pop_front();
          check("sum", sum, mon_e.s);
          check("cout", cout, mon_e.c);
          check("overflow", overflow, mon_e.o);
        end
      end
      prev_stall = out_valid && !out_ready;
      ps = sum; pc = cout; po = overflow;
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int st0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_out_valid", out_valid, 0);
    check("rst_sum", sum, 0);
    check("rst_in_ready", in_ready, 1);
    rst_n = 1'b1;
    send(16'hffff, 16'h0001, 0, 0, 0, 0, '{16'h0000, 1'b1, 1'b1});
    @(negedge clk); check("lat_stage1", out_valid, 0);
    @(negedge clk); check("lat_stage2", out_valid, 1);
    drain();
    send(16'hffff, 16'h0001, 0, 0, 0, 1, '{16'hffff, 1'b1, 1'b1}); drain();
    send(16'h7fff, 16'h0001, 0, 0, 1, 0, '{16'h8000, 1'b0, 1'b1}); drain();
    send(16'h7fff, 16'h0001, 0, 0, 1, 1, '{16'h7fff, 1'b0, 1'b1}); drain();
    send(16'h0000, 16'h0001, 0, 1, 0, 0, '{16'hffff, 1'b0, 1'b1}); drain();
    send(16'h0000, 16'h0001, 0, 1, 0, 1, '{16'h0000, 1'b0, 1'b1}); drain();
    send(16'h0000, 16'h0001, 0, 1, 1, 0, '{16'hffff, 1'b0, 1'b0}); drain();
    send(16'h8000, 16'h0001, 0, 1, 1, 1, '{16'h8000, 1'b1, 1'b1}); drain();
    send(16'hfffe, 16'h0000, 1, 0, 0, 1, '{16'hffff, 1'b0, 1'b0}); drain();
    send(16'h0005, 16'h0003, 1, 1, 0, 1, '{16'h0001, 1'b1, 1'b0}); drain();
    st0 = stall_seen;
    fork
      for (int i = 0; i < 8; i++) send_rand();
      begin
        repeat (3) @(posedge clk);
        #1; out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1; out_ready = 1'b1;
      end
    join
    drain();
    check("stall_cycles", stall_seen - st0, 3);
    fork
      for (int i = 0; i < 40; i++) send_rand();
      for (int i = 0; i < 60; i++) begin
        @(posedge clk);
        #1; out_ready = ($urandom_range(0, 3) != 0);
      end
    join
    out_ready = 1'b1;
    drain();
    send(16'h1234, 16'h1111, 0, 0, 0, 0, '{16'h2345, 1'b0, 1'b0});
    send(16'h4321, 16'h0001, 0, 1, 0, 0, '{16'h4320, 1'b1, 1'b0});
    #1; rst_n = 1'b0;
    #1;
    check("midrst_out_valid", out_valid, 0);
    check("midrst_sum", sum, 0);
    check("midrst_cout", cout, 0);
    check("midrst_ovf", overflow, 0);
    check("midrst_in_ready", in_ready, 1);
    sb.delete();
    repeat (2) @(posedge clk);
    #1; rst_n = 1'b1;
    repeat (4) @(negedge clk);
    check("post_rst_idle", out_valid, 0);
    @(posedge clk);
    #1;
    send(16'h00ff, 16'h0f01, 0, 0, 0, 0, '{16'h1000, 1'b0, 1'b0});
    @(negedge clk); check("rst_lat_stage1", out_valid, 0);
    @(negedge clk); check("rst_lat_stage2", out_valid, 1);
    drain();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
